// File: rtl/grid_robot_if.sv
// grid_robot_if
//   Command handshake bundle between a command source and grid_robot.
//   Parameter:
//     CNT_W     width of the step-count field
//   Signals:
//     cmd_valid  source -> robot   a command is present
//     cmd_ready  robot  -> source  the robot can take a command this cycle
//     cmd_dir    source -> robot   direction, N=0 E=1 S=2 W=3
//     cmd_steps  source -> robot   number of steps requested
//   Modports: master (command source), slave (robot).
interface grid_robot_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_dir;
    logic [CNT_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/grid_robot.sv
// grid_robot
//   Command-driven grid-walking robot. Accepts move commands (direction and
//   step count) over a valid/ready handshake and walks one step per clock
//   inside a BOUND_X x BOUND_Y grid. In the default build a step that would
//   leave the grid is blocked: the command aborts and a saturating bump
//   counter increments. Defining GRID_ROBOT_WRAP_EN makes the grid toroidal,
//   so steps never block and commands always run to completion.
//   Ports:
//     clk         clock, all state on the rising edge
//     rst_n       asynchronous active-low reset
//     cmd         grid_robot_if.slave command handshake
//     x, y        registered current position
//     busy        a command is executing
//     done        one-cycle pulse when a command completes or aborts
//     bump        one-cycle pulse when a step is blocked by a wall
//     bump_count  saturating count of bumps since reset
module grid_robot #(
    parameter int WIDTH   = 5,
    parameter int BOUND_X = 10,
    parameter int BOUND_Y = 10,
    parameter int STEP    = 1,
    parameter int CNT_W   = 4,
    parameter int BUMP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    grid_robot_if.slave       cmd,
    output logic [WIDTH-1:0]  x,
    output logic [WIDTH-1:0]  y,
    output logic              busy,
    output logic              done,
    output logic              bump,
    output logic [BUMP_W-1:0] bump_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MOVE = 1'b1;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] BND_X  = (WIDTH+1)'(BOUND_X);
    localparam logic [WIDTH:0] BND_Y  = (WIDTH+1)'(BOUND_Y);

    logic [0:0]       state;
    logic [1:0]       dir_q;
    logic [CNT_W-1:0] remaining;

    logic [WIDTH:0]   cand;
    logic             blocked;
    logic [WIDTH-1:0] next_x;
    logic [WIDTH-1:0] next_y;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == MOVE);

    // Candidate position for the latched direction. The extra top bit lets
    // the upper-wall compare see x+STEP / y+STEP without overflow.
    always_comb begin
        cand    = '0;
        blocked = 1'b0;
        next_x  = x;
        next_y  = y;
        case (dir_q)
            DIR_N: begin
                cand = {1'b0, y} + STEP_X;
                if (cand >= BND_Y) begin
`ifdef GRID_ROBOT_WRAP_EN
                    cand = cand - BND_Y;
`else
                    blocked = 1'b1;
`endif
                end
                next_y = cand[WIDTH-1:0];
            end
            DIR_S: begin
                if ({1'b0, y} < STEP_X) begin
`ifdef GRID_ROBOT_WRAP_EN
                    cand = {1'b0, y} + BND_Y - STEP_X;
`else
                    cand    = {1'b0, y};
                    blocked = 1'b1;
`endif
                end else begin
                    cand = {1'b0, y} - STEP_X;
                end
                next_y = cand[WIDTH-1:0];
            end
            DIR_E: begin
                cand = {1'b0, x} + STEP_X;
                if (cand >= BND_X) begin
`ifdef GRID_ROBOT_WRAP_EN
                    cand = cand - BND_X;
`else
                    blocked = 1'b1;
`endif
                end
                next_x = cand[WIDTH-1:0];
            end
            default: begin
                if ({1'b0, x} < STEP_X) begin
`ifdef GRID_ROBOT_WRAP_EN
                    cand = {1'b0, x} + BND_X - STEP_X;
`else
                    cand    = {1'b0, x};
                    blocked = 1'b1;
`endif
                end else begin
                    cand = {1'b0, x} - STEP_X;
                end
                next_x = cand[WIDTH-1:0];
            end
        endcase
    end

    // Command FSM, position registers and bump counter. done and bump
    // default low each cycle so they only ever pulse for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir_q      <= DIR_N;
            remaining  <= '0;
            x          <= '0;
            y          <= '0;
            done       <= 1'b0;
            bump       <= 1'b0;
            bump_count <= '0;
        end else begin
            done <= 1'b0;
            bump <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (cmd.cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            dir_q     <= cmd.cmd_dir;
                            remaining <= cmd.cmd_steps;
                            state     <= MOVE;
                        end
                    end
                end
                default: begin
                    if (blocked) begin
                        bump  <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                        if (bump_count != '1) begin
                            bump_count <= bump_count + BUMP_W'(1);
                        end
                    end else begin
                        x         <= next_x;
                        y         <= next_y;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_robot.sv
// tb_grid_robot
//   Self-checking bench for grid_robot. Expected end-of-command results
//   (position, bump, bump_count, latency) are pushed to a scoreboard queue
//   when a command is driven and popped when the robot pulses done.
//   Expectations follow the wall build by default and the toroidal build
//   when GRID_ROBOT_WRAP_EN is defined.
module tb_grid_robot;

    localparam int WIDTH   = 5;
    localparam int BOUND_X = 10;
    localparam int BOUND_Y = 10;
    localparam int STEP    = 1;
    localparam int CNT_W   = 4;
    localparam int BUMP_W  = 8;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] E = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam logic [1:0] W = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              busy;
    logic              done;
    logic              bump;
    logic [BUMP_W-1:0] bump_count;

    grid_robot_if #(.CNT_W(CNT_W)) cmd_if ();

    grid_robot #(
        .WIDTH(WIDTH), .BOUND_X(BOUND_X), .BOUND_Y(BOUND_Y),
        .STEP(STEP), .CNT_W(CNT_W), .BUMP_W(BUMP_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd_if),
        .x(x),
        .y(y),
        .busy(busy),
        .done(done),
        .bump(bump),
        .bump_count(bump_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int bump;
        int bc;
        int lat;
    } exp_t;

    typedef struct {
        logic [1:0] dir;
        int         steps;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks = 0;
    int   miscompares = 0;

    function automatic exp_t make_exp(int ex, int ey, int eb, int ebc, int elat);
        exp_t r;
        r.x = ex; r.y = ey; r.bump = eb; r.bc = ebc; r.lat = elat;
        return r;
    endfunction

    function automatic vec_t make_vec(logic [1:0] d, int st, exp_t e);
        vec_t r;
        r.dir = d; r.steps = st; r.e = e;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = N;
        cmd_if.cmd_steps = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one command from a negedge; returns just after the accepting
    // edge. With hold set, cmd_valid stays high for a back-to-back command.
    task automatic applyStimulus(input logic [1:0] dir, input int steps, input bit hold);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = CNT_W'(steps);
        checkOutput("ready_before_accept", int'(cmd_if.cmd_ready), 1);
        @(posedge clk);
        #1;
        if (!hold) cmd_if.cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for done, counting negedges since the accepting edge,
    // then pops the scoreboard and compares.
    task automatic wait_done(input string name, input int start_cyc, input bit check_after);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = start_cyc;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: got no done, expected done within 40 cycles", name);
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++;
            miscompares++;
            $display("[TB] FAIL %s_unexpected_done: got done, expected none", name);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_x"}, int'(x), e.x);
            checkOutput({name, "_y"}, int'(y), e.y);
            checkOutput({name, "_bump"}, int'(bump), e.bump);
            checkOutput({name, "_bump_count"}, int'(bump_count), e.bc);
            checkOutput({name, "_latency"}, cyc, e.lat);
            checkOutput({name, "_ready_in_done"}, int'(cmd_if.cmd_ready), 1);
            checkOutput({name, "_busy_in_done"}, int'(busy), 0);
            if (check_after) begin
                @(negedge clk);
                checkOutput({name, "_done_pulse"}, int'(done), 0);
                checkOutput({name, "_bump_pulse"}, int'(bump), 0);
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
`ifdef GRID_ROBOT_WRAP_EN
        vecs[0] = make_vec(S, 1,  make_exp(0, 9, 0, 0, 2));
        vecs[1] = make_vec(E, 9,  make_exp(9, 9, 0, 0, 10));
        vecs[2] = make_vec(E, 1,  make_exp(0, 9, 0, 0, 2));
        vecs[3] = make_vec(N, 1,  make_exp(0, 0, 0, 0, 2));
        vecs[4] = make_vec(W, 3,  make_exp(7, 0, 0, 0, 4));
        vecs[5] = make_vec(N, 15, make_exp(7, 5, 0, 0, 16));
        vecs[6] = make_vec(S, 0,  make_exp(7, 5, 0, 0, 1));
        vecs[7] = make_vec(S, 7,  make_exp(7, 8, 0, 0, 8));
`else
        vecs[0] = make_vec(N, 3,  make_exp(0, 3, 0, 0, 4));
        vecs[1] = make_vec(W, 2,  make_exp(0, 3, 1, 1, 2));
        vecs[2] = make_vec(E, 15, make_exp(9, 3, 1, 2, 11));
        vecs[3] = make_vec(S, 0,  make_exp(9, 3, 0, 2, 1));
        vecs[4] = make_vec(S, 5,  make_exp(9, 0, 1, 3, 5));
        vecs[5] = make_vec(N, 9,  make_exp(9, 9, 0, 3, 10));
        vecs[6] = make_vec(E, 1,  make_exp(9, 9, 1, 4, 2));
        vecs[7] = make_vec(W, 4,  make_exp(5, 9, 0, 4, 5));
`endif

        // Reset values.
        reset_dut();
        checkOutput("reset_x", int'(x), 0);
        checkOutput("reset_y", int'(y), 0);
        checkOutput("reset_ready", int'(cmd_if.cmd_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_bump", int'(bump), 0);
        checkOutput("reset_bump_count", int'(bump_count), 0);

        // West from the origin: wall hit on the first step, or wrap to x=8.
`ifdef GRID_ROBOT_WRAP_EN
        sb.push_back(make_exp(8, 0, 0, 0, 3));
`else
        sb.push_back(make_exp(0, 0, 1, 1, 2));
`endif
        applyStimulus(W, 2, 1'b0);
        @(negedge clk);
        checkOutput("w2_busy", int'(busy), 1);
        checkOutput("w2_ready_low", int'(cmd_if.cmd_ready), 0);
        wait_done("w2", 1, 1'b1);

        // Asynchronous reset two steps into a five-step north move.
        applyStimulus(N, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_mid_y", int'(y), i);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_x", int'(x), 0);
        checkOutput("rst_async_y", int'(y), 0);
        checkOutput("rst_async_ready", int'(cmd_if.cmd_ready), 1);
        checkOutput("rst_async_busy", int'(busy), 0);
        checkOutput("rst_async_bump_count", int'(bump_count), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_release_no_done", int'(done), 0);
        end

        // North three steps: one step per edge, ready low for three cycles.
        sb.push_back(make_exp(0, 3, 0, 0, 4));
        applyStimulus(N, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("n3_ready_low", int'(cmd_if.cmd_ready), 0);
            checkOutput("n3_y_step", int'(y), i);
            checkOutput("n3_x_hold", int'(x), 0);
        end
        wait_done("n3", 3, 1'b1);

        // East fifteen from the origin: stops at x=9 on a wall, or wraps to 5.
        reset_dut();
`ifdef GRID_ROBOT_WRAP_EN
        sb.push_back(make_exp(5, 0, 0, 0, 16));
`else
        sb.push_back(make_exp(9, 0, 1, 1, 11));
`endif
        applyStimulus(E, 15, 1'b0);
        wait_done("e15", 0, 1'b1);

        // Zero-step command then a back-to-back one-step north with valid held.
        reset_dut();
        sb.push_back(make_exp(0, 0, 0, 0, 1));
        applyStimulus(N, 0, 1'b1);
        cmd_if.cmd_steps = CNT_W'(1);
        wait_done("zero_steps", 0, 1'b0);
        sb.push_back(make_exp(0, 1, 0, 0, 2));
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        wait_done("back_to_back", 0, 1'b1);

        // Table of commands run in sequence from the origin.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            sb.push_back(vecs[i].e);
            applyStimulus(vecs[i].dir, vecs[i].steps, 1'b0);
            wait_done($sformatf("vec%0d", i), 0, 1'b1);
        end

        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule

// File: doc/grid_robot.md
# grid_robot

Parametrised grid-walking robot: a command-driven successor to the single-step robot. It accepts move commands over a valid/ready handshake, each naming a cardinal direction and a step count. It executes one step per cycle inside a BOUND_X × BOUND_Y grid, aborts a command on a wall hit, and counts wall hits. It sits between a command source (planner or testbench) and position consumers.

## Interface
- WIDTH, 5: coordinate width; requires BOUND_X, BOUND_Y ≤ 2**WIDTH.
- BOUND_X, 10: legal x range 0..BOUND_X-1.
- BOUND_Y, 10: legal y range 0..BOUND_Y-1.
- STEP, 1: distance per step; requires 1 ≤ STEP < min(BOUND_X, BOUND_Y).
- CNT_W, 4: width of step-count field.
- BUMP_W, 8: width of bump counter.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset. One clock and this one reset; no other reset source.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  2  direction: N=0, E=1, S=2, W=3.
- cmd_steps  in  CNT_W  number of steps requested.
- x  out  WIDTH  current x position.
- y  out  WIDTH  current y position.
- busy  out  1  command executing.
- done  out  1  one-cycle pulse when a command completes or aborts.
- bump  out  1  one-cycle pulse when a step is blocked by a wall.
- bump_count  out  BUMP_W  saturating count of bumps since reset.

## Operation
- States: IDLE, MOVE.
- In IDLE:
  - cmd_ready=1, busy=0.
  - Acceptance = cmd_valid && cmd_ready at a rising edge.
  - On accept with cmd_steps≠0: latch dir, remaining=cmd_steps, go to MOVE.
  - On accept with cmd_steps=0: set done, stay in IDLE, no movement.
- In MOVE:
  - cmd_ready=0, busy=1. cmd_valid is ignored; held commands wait.
  - Each edge, compute the candidate position in WIDTH+1 bits:
    - N: y+STEP, blocked if ≥ BOUND_Y.
    - E: x+STEP, blocked if ≥ BOUND_X.
    - S: blocked if y < STEP, else y-STEP.
    - W: blocked if x < STEP, else x-STEP.
  - Not blocked: update the coordinate and decrement remaining. If remaining was 1, set done and go to IDLE.
  - Blocked: the position holds. Set bump and done, increment bump_count, discard remaining, go to IDLE.
- Coordinates never leave the legal range, with or without wrap.
- bump_count saturates at 2**BUMP_W-1 and never wraps.
- Reset: x=0, y=0, state=IDLE, cmd_ready=1, busy=0, done=0, bump=0, bump_count=0.
  - Applies asynchronously, including mid-command. The aborted command produces no done.

## Timing
- Accept at edge N with cmd_steps=k>0 and no bump:
  - Position updates at edges N+1..N+k.
  - done is high during the cycle after edge N+k.
  - cmd_ready is low from after edge N until edge N+k. It is high in the done cycle, so the next command can be accepted at edge N+k+1.
- Bump on the j-th step: bump and done are both high in the cycle after edge N+j, and cmd_ready is high in that cycle.
- cmd_steps=0 accepted at edge N: done is high in the cycle after edge N.
- done and bump are registered. cmd_ready and busy are decoded from state.
- Outputs x and y are registered, with no combinational path from cmd_*.

## Configuration
- GRID_ROBOT_WRAP_EN defined: the grid is toroidal and a step never blocks.
  - N: y+STEP-BOUND_Y when y+STEP ≥ BOUND_Y.
  - S: y+BOUND_Y-STEP when y < STEP.
  - E and W wrap the same way on BOUND_X.
  - bump stays 0 and bump_count stays 0. Commands always run their full step count.
- Not defined: wall behaviour as described in Operation.

## Test plan
- Reset: drive rst_n low mid-MOVE (after 2 of 5 N steps) → x=0, y=0, cmd_ready=1, busy=0, bump_count=0 immediately without a clock edge; no done pulse.
- From (0,0), N with steps=3 → y=1,2,3 on three consecutive edges; done for exactly one cycle; cmd_ready low for 3 cycles; x stays 0.
- From (0,0), W with steps=2 → x stays 0; bump and done together one cycle after the first MOVE edge; bump_count=1; back in IDLE.
- From (0,0), E with steps=15 → x reaches 9 after 9 edges; bump on the 10th edge; done; bump_count increments by 1.
- steps=0 accepted, then a back-to-back N steps=1 with cmd_valid held → done one cycle after the first accept; second command accepted on the next edge; y=1.
- With GRID_ROBOT_WRAP_EN: from (0,0), S steps=1 → y=9 with no bump; then from x=9, E steps=1 → x=0; bump_count remains 0.
